gpio_irq_ctrl: RTL and testbench

// Parametrised GPIO peripheral for the tinyQV SoC: WIDTH output pins with per-pin select between
// CPU-driven level and a peripheral alternate function, WIDTH synchronised inputs, and per-pin

---
 rtl/gpio_irq_ctrl.sv | 121 ++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// GPIO peripheral: per-pin output select, synchronised inputs,
// edge-triggered interrupts with sticky write-1-to-clear pending bits.
module gpio_irq_ctrl #(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sel,
    input  logic [2:0]       addr,
    input  logic [1:0]       write_n,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [WIDTH-1:0] periph_out,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] in_sync,
    output logic             irq
);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_IN   = 3'd1;
    localparam logic [2:0] A_SEL  = 3'd2;
    localparam logic [2:0] A_RISE = 3'd3;
    localparam logic [2:0] A_FALL = 3'd4;
    localparam logic [2:0] A_PEND = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sel_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    logic             we;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] pend_clr;
    logic [WIDTH-1:0] event_set;
    logic [WIDTH-1:0] rd;

    assign we = sel && (write_n != 2'b11);

    always_comb begin
        lane_mask = '0;
        case (write_n)
            2'b00:   lane_mask = 32'h0000_00ff;
            2'b01:   lane_mask = 32'h0000_ffff;
            2'b10:   lane_mask = 32'hffff_ffff;
            default: lane_mask = '0;
        endcase
    end

    assign wmask = we ? lane_mask[WIDTH-1:0] : '0;
    assign wbits = data_in[WIDTH-1:0] & wmask;

    always_comb begin
        out_nxt = out_q;
        unique case (addr)
            A_OUT:   out_nxt = (out_q & ~wmask) | wbits;
            A_SET:   out_nxt = out_q | wbits;
            A_CLR:   out_nxt = out_q & ~wbits;
            default: out_nxt = out_q;
        endcase
    end

    assign in_sync   = sync_q[SYNC_STAGES-1];
    assign pend_clr  = (addr == A_PEND) ? wbits : '0;
    assign event_set = (in_sync & ~prev_q & rise_q)
                     | (~in_sync & prev_q & fall_q);

    // A new event in the same cycle as its W1C leaves the bit set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q  <= OUT_RESET;
            sel_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            sync_q <= '0;
            irq    <= 1'b0;
        end else begin
            out_q <= out_nxt;
            if (addr == A_SEL)
                sel_q <= (sel_q & ~wmask) | wbits;
            if (addr == A_RISE)
                rise_q <= (rise_q & ~wmask) | wbits;
            if (addr == A_FALL)
                fall_q <= (fall_q & ~wmask) | wbits;
            pend_q <= (pend_q & ~pend_clr) | event_set;
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= in_sync;
            irq    <= |pend_q;
        end
    end

    always_comb begin
        rd = '0;
        unique case (addr)
            A_OUT, A_SET, A_CLR: rd = out_q;
            A_IN:                rd = in_sync;
            A_SEL:               rd = sel_q;
            A_RISE:              rd = rise_q;
            A_FALL:              rd = fall_q;
            A_PEND:              rd = pend_q;
            default:             rd = '0;
        endcase
    end

    assign data_out = sel ? 32'(rd) : 32'd0;

    assign gpio_out = (sel_q & out_q) | (~sel_q & periph_out);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed and randomised checks of gpio_irq_ctrl against a
// history-based model of input latency and edge interrupts.
module tb_gpio_irq_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sel;
    logic [2:0]    addr;
    logic [1:0]    write_n;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  periph_out;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  in_sync;
    logic          irq;

    int total = 0;
    int bad = 0;

    gpio_irq_ctrl #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .OUT_RESET(16'h00A5)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sel(sel),
        .addr(addr),
        .write_n(write_n),
        .data_in(data_in),
        .data_out(data_out),
        .gpio_in(gpio_in),
        .periph_out(periph_out),
        .gpio_out(gpio_out),
        .in_sync(in_sync),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      input logic [1:0] wn);
        sel = 1'b1;
        addr = a;
        write_n = wn;
        data_in = d;
        tick();
        sel = 1'b0;
        write_n = 2'b11;
        data_in = '0;
    endtask

    task automatic rdchk(input logic [2:0] a, input logic [31:0] exp,
                         input string tag);
        sel = 1'b1;
        addr = a;
        write_n = 2'b11;
        #1;
        chk(tag, data_out, exp);
        sel = 1'b0;
    endtask

    logic [W-1:0] hist[$];
    logic [W-1:0] m_pend;
    logic [W-1:0] m_ren;
    logic [W-1:0] m_fen;
    logic         m_irq;

    initial begin
        sel = 0;
        addr = 0;
        write_n = 2'b11;
        data_in = 0;
        gpio_in = 0;
        periph_out = 16'h3C5A;
        rstn = 0;
        #12;
        chk("rst_gpio_out", 32'(gpio_out), 32'h3C5A);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_in_sync", 32'(in_sync), 32'h0);
        rdchk(3'd0, 32'h00A5, "rst_out");
        rdchk(3'd5, 32'h0, "rst_pend");
        rstn = 1;
        tick();

        wr(3'd2, 32'hFFFF, 2'b10);
        chk("sel_gpio_out", 32'(gpio_out), 32'h00A5);

        wr(3'd0, 32'h1234_5678, 2'b10);
        wr(3'd0, 32'h0000_0000, 2'b00);
        rdchk(3'd0, 32'h5600, "byte_write");
        wr(3'd0, 32'hABCD_1234, 2'b01);
        rdchk(3'd0, 32'h1234, "half_write");
        wr(3'd1, 32'hFFFF, 2'b10);
        rdchk(3'd1, 32'h0, "in_ro");

        wr(3'd3, 32'h0008, 2'b10);
        gpio_in = 16'h0008;
        tick();
        rdchk(3'd1, 32'h0, "in_k");
        tick();
        rdchk(3'd1, 32'h0008, "in_k1");
        rdchk(3'd5, 32'h0, "pend_k1");
        tick();
        rdchk(3'd5, 32'h0008, "pend_k2");
        chk("irq_k2", 32'(irq), 32'h0);
        tick();
        chk("irq_k3", 32'(irq), 32'h1);
        wr(3'd5, 32'h0008, 2'b00);
        rdchk(3'd5, 32'h0, "pend_w1c");
        tick();
        chk("irq_w1c", 32'(irq), 32'h0);

        gpio_in = 16'h0009;
        repeat (4) tick();
        rdchk(3'd5, 32'h0, "no_rise_bit0");
        wr(3'd4, 32'h0001, 2'b10);
        gpio_in = 16'h0008;
        tick();
        tick();
        wr(3'd5, 32'h0001, 2'b00);
        rdchk(3'd5, 32'h0001, "set_wins");
        wr(3'd4, 32'h0000, 2'b10);
        rdchk(3'd5, 32'h0001, "en_keeps_pend");
        wr(3'd5, 32'h0001, 2'b00);
        rdchk(3'd5, 32'h0, "pend_clr0");

        wr(3'd0, 32'h00F0, 2'b10);
        wr(3'd6, 32'h000F, 2'b00);
        rdchk(3'd6, 32'h00FF, "out_set");
        wr(3'd7, 32'h0081, 2'b00);
        rdchk(3'd7, 32'h007E, "out_clr");
        sel = 1'b0;
        addr = 3'd0;
        write_n = 2'b10;
        data_in = 32'hFFFF;
        tick();
        write_n = 2'b11;
        rdchk(3'd0, 32'h007E, "nosel_write");
        chk("gpio_out_sel", 32'(gpio_out), 32'h007E);
        #1;
        chk("data_out_nosel", data_out, 32'h0);

        // Random phase from a fresh reset: input history drives the model
        gpio_in = 0;
        rstn = 0;
        #2;
        rstn = 1;
        tick();
        hist = '{16'h0, 16'h0, 16'h0};
        m_pend = 0;
        m_ren = 0;
        m_fen = 0;
        m_irq = 0;
        for (int c = 0; c < 300; c++) begin
            logic [W-1:0] gin;
            logic [W-1:0] a2;
            logic [W-1:0] a3;
            logic [W-1:0] evs;
            logic [W-1:0] clr;
            logic [W-1:0] wd;
            logic [2:0]   wa;
            logic         dw;
            gin = W'($urandom);
            dw = ($urandom_range(0, 3) == 0);
            wa = 3'($urandom_range(3, 5));
            wd = ($urandom_range(0, 2) == 0) ? 16'hFFFF : W'($urandom);
            sel = dw;
            addr = wa;
            write_n = dw ? 2'b10 : 2'b11;
            data_in = 32'(wd);
            gpio_in = gin;
            a2 = hist[hist.size()-2];
            a3 = hist[hist.size()-3];
            evs = (a2 & ~a3 & m_ren) | (~a2 & a3 & m_fen);
            clr = (dw && wa == 3'd5) ? wd : '0;
            m_irq = |m_pend;
            m_pend = (m_pend & ~clr) | evs;
            if (dw && wa == 3'd3) m_ren = wd;
            if (dw && wa == 3'd4) m_fen = wd;
            hist.push_back(gin);
            void'(hist.pop_front());
            tick();
            sel = 0;
            write_n = 2'b11;
            chk("rnd_in_sync", 32'(in_sync), 32'(hist[hist.size()-2]));
            chk("rnd_irq", 32'(irq), 32'(m_irq));
            rdchk(3'd5, 32'(m_pend), "rnd_pend");
        end

        wr(3'd3, 32'hFFFF, 2'b10);
        wr(3'd4, 32'hFFFF, 2'b10);
        gpio_in = 0;
        repeat (4) tick();
        wr(3'd5, 32'hFFFF, 2'b10);
        gpio_in = 16'hFFFF;
        repeat (3) tick();
        rdchk(3'd5, 32'hFFFF, "burst_pend");
        tick();
        chk("burst_irq", 32'(irq), 32'h1);
        #2;
        rstn = 0;
        #1;
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_in_sync", 32'(in_sync), 32'h0);
        chk("mid_rst_gpio_out", 32'(gpio_out), 32'h3C5A);
        rdchk(3'd5, 32'h0, "mid_rst_pend");
        rdchk(3'd0, 32'h00A5, "mid_rst_out");
        rstn = 1;
        repeat (5) tick();
        rdchk(3'd5, 32'h0, "post_rst_no_event");
        chk("post_rst_in_sync", 32'(in_sync), 32'hFFFF);
        chk("post_rst_irq", 32'(irq), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
